// File: rtl/mprj_io_ctrl.sv
// Caravel user I/O pad controller: per-pad core/register output mux, synchronised
// input readback and sticky edge interrupts, all managed over a Wishbone slave.
module mprj_io_ctrl #(
    parameter int          NPADS       = 38,
    parameter int          NIRQ        = 3,
    parameter logic [31:0] BASE_ADDR   = 32'h3000_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             wbs_cyc_i,
    input  logic             wbs_stb_i,
    input  logic             wbs_we_i,
    input  logic [3:0]       wbs_sel_i,
    input  logic [31:0]      wbs_adr_i,
    input  logic [31:0]      wbs_dat_i,
    output logic             wbs_ack_o,
    output logic [31:0]      wbs_dat_o,
    input  logic [NPADS-1:0] core_out,
    input  logic [NPADS-1:0] core_oeb,
    output logic [NPADS-1:0] core_in,
    input  logic [NPADS-1:0] io_in,
    output logic [NPADS-1:0] io_out,
    output logic [NPADS-1:0] io_oeb,
    output logic [NIRQ-1:0]  irq
);

    localparam logic [63:0] PAD_MASK = (NPADS >= 64) ? {64{1'b1}}
                                                     : ((64'd1 << NPADS) - 64'd1);

    logic [63:0] sel_r, out_r, oe_r, ien_r, edge_r, stat_r;

    logic [NPADS-1:0] sync_q [SYNC_STAGES];
    logic [NPADS-1:0] s, s_d;
    logic [63:0]      s64, sd64, ev64;

    logic             in_window, req, wr;
    logic [3:0]       word;
    logic [31:0]      wmask, rdata;
    logic [63:0]      wm64, wd64, rd64, stat_clr;
    logic [NPADS-1:0] pend;
    logic [NIRQ-1:0]  irq_next;
    logic             unused_adr;

    assign unused_adr = ^wbs_adr_i[1:0];

    assign core_in = io_in;
    assign io_out  = (sel_r[NPADS-1:0] & out_r[NPADS-1:0]) | (~sel_r[NPADS-1:0] & core_out);
    assign io_oeb  = (sel_r[NPADS-1:0] & ~oe_r[NPADS-1:0]) | (~sel_r[NPADS-1:0] & core_oeb);

    // The ~ack term forces an idle cycle between back-to-back accesses.
    assign in_window = (wbs_adr_i[31:6] == BASE_ADDR[31:6]);
    assign req       = wbs_cyc_i & wbs_stb_i & ~wbs_ack_o & in_window;
    assign wr        = req & wbs_we_i;
    assign word      = wbs_adr_i[5:2];

    assign wmask = {{8{wbs_sel_i[3]}}, {8{wbs_sel_i[2]}}, {8{wbs_sel_i[1]}}, {8{wbs_sel_i[0]}}};
    assign wm64  = word[0] ? {wmask, 32'h0} : {32'h0, wmask};
    assign wd64  = word[0] ? {wbs_dat_i, 32'h0} : {32'h0, wbs_dat_i};

    function automatic logic [63:0] merge(input logic [63:0] cur, input logic [63:0] m,
                                          input logic [63:0] d);
        return ((cur & ~m) | (d & m)) & PAD_MASK;
    endfunction

    assign s    = sync_q[SYNC_STAGES-1];
    assign s64  = 64'(s);
    assign sd64 = 64'(s_d);
    assign ev64 = PAD_MASK & ((edge_r & s64 & ~sd64) | (~edge_r & ~s64 & sd64));

    assign stat_clr = (wr && word[3:1] == 3'd6) ? (wd64 & wm64) : 64'h0;
    assign pend     = stat_r[NPADS-1:0] & ien_r[NPADS-1:0];

    always_comb begin
        rd64 = 64'h0;
        case (word[3:1])
            3'd0:    rd64 = sel_r;
            3'd1:    rd64 = out_r;
            3'd2:    rd64 = oe_r;
            3'd3:    rd64 = s64;
            3'd4:    rd64 = ien_r;
            3'd5:    rd64 = edge_r;
            3'd6:    rd64 = stat_r;
            default: rd64 = 64'h0;
        endcase
        rdata = word[0] ? rd64[63:32] : rd64[31:0];
    end

    always_comb begin
        irq_next = '0;
        for (int i = 0; i < NPADS; i++) begin
            if (pend[i]) irq_next[i % NIRQ] = 1'b1;
        end
    end

    // s and s_d clear together, so reset release never looks like an edge.
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            for (int j = 0; j < SYNC_STAGES; j++) sync_q[j] <= '0;
            s_d <= '0;
        end else begin
            sync_q[0] <= io_in;
            for (int j = 1; j < SYNC_STAGES; j++) sync_q[j] <= sync_q[j-1];
            s_d <= s;
        end
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            wbs_ack_o <= 1'b0;
            wbs_dat_o <= 32'h0;
            sel_r     <= 64'h0;
            out_r     <= 64'h0;
            oe_r      <= 64'h0;
            ien_r     <= 64'h0;
            edge_r    <= 64'h0;
            stat_r    <= 64'h0;
            irq       <= '0;
        end else begin
            wbs_ack_o <= req;
            wbs_dat_o <= (req & ~wbs_we_i) ? rdata : 32'h0;
            if (wr) begin
                case (word[3:1])
                    3'd0:    sel_r  <= merge(sel_r, wm64, wd64);
                    3'd1:    out_r  <= merge(out_r, wm64, wd64);
                    3'd2:    oe_r   <= merge(oe_r, wm64, wd64);
                    3'd4:    ien_r  <= merge(ien_r, wm64, wd64);
                    3'd5:    edge_r <= merge(edge_r, wm64, wd64);
                    default: ;
                endcase
            end
            // An edge arriving with a clear of the same bit keeps the bit set.
            stat_r <= (stat_r & ~stat_clr) | ev64;
            irq    <= irq_next;
        end
    end

endmodule

// File: tb/tb_mprj_io_ctrl.sv
// Bench for mprj_io_ctrl: Wishbone reads are scored against an expected-value queue,
// pad mux and interrupt behaviour are checked directly against bench-computed values.
module tb_mprj_io_ctrl;

    localparam int          NPADS = 38;
    localparam int          NIRQ  = 3;
    localparam logic [31:0] BASE  = 32'h3000_0000;
    localparam int          SYNC  = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             cyc, stb, we;
    logic [3:0]       sel;
    logic [31:0]      adr, dat;
    logic             ack;
    logic [31:0]      dat_o;
    logic [NPADS-1:0] core_out, core_oeb, core_in, io_in, io_out, io_oeb;
    logic [NIRQ-1:0]  irq;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    mprj_io_ctrl #(.NPADS(NPADS), .NIRQ(NIRQ), .BASE_ADDR(BASE), .SYNC_STAGES(SYNC)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .wbs_cyc_i(cyc), .wbs_stb_i(stb), .wbs_we_i(we), .wbs_sel_i(sel),
        .wbs_adr_i(adr), .wbs_dat_i(dat), .wbs_ack_o(ack), .wbs_dat_o(dat_o),
        .core_out(core_out), .core_oeb(core_oeb), .core_in(core_in),
        .io_in(io_in), .io_out(io_out), .io_oeb(io_oeb), .irq(irq)
    );

    // One bus access; returns data seen with ack, whether ack came, its latency in
    // cycles after the strobe, and (when hold=1) ack one cycle later with stb still up.
    task automatic bus(input logic we_v, input logic [7:0] off, input logic [31:0] d,
                       input logic [3:0] s_v, input bit hold, output logic [31:0] rd,
                       output bit got, output int lat, output logic ack2);
        got = 0; lat = 0; rd = 32'h0; ack2 = 1'bx;
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = we_v; adr = BASE + 32'(off); dat = d; sel = s_v;
        for (int k = 1; k <= 8 && !got; k++) begin
            @(posedge clk); #1;
            if (ack) begin got = 1; lat = k; rd = dat_o; end
        end
        if (got && hold) begin @(posedge clk); #1; ack2 = ack; end
        cyc = 0; stb = 0; we = 0;
    endtask

    task automatic test_reset;
        logic [31:0] rd, e; bit got; int lat; logic a2;
        rst = 1; cyc = 0; stb = 0; we = 0; sel = 4'h0; adr = 32'h0; dat = 32'h0;
        io_in = '0; core_out = 38'h15; core_oeb = 38'h2A_5A5A_C3C3;
        repeat (3) @(posedge clk); #1;
        n_tests++;
        if (ack !== 1'b0 || dat_o !== 32'h0 || irq !== 3'b000) begin
            n_fail++; $display("FAIL reset_outputs: ack=%b dat=%h irq=%b want 0/0/0", ack, dat_o, irq);
        end
        rst = 0;
        @(posedge clk); #1;
        n_tests++;
        if (io_out !== 38'h15 || io_oeb !== core_oeb) begin
            n_fail++; $display("FAIL reset_passthru: io_out=%h io_oeb=%h want 15/%h", io_out, io_oeb, core_oeb);
        end
        io_in = 38'h12_3456_789A; #1;
        n_tests++;
        if (core_in !== io_in) begin
            n_fail++; $display("FAIL core_in: got %h want %h", core_in, io_in);
        end
        io_in = '0;
        repeat (4) @(posedge clk);
        for (int w = 0; w < 16; w++) begin
            exp_q.push_back(32'h0);
            bus(1'b0, 8'(w * 4), 32'h0, 4'hF, 1'b0, rd, got, lat, a2);
            e = exp_q.pop_front();
            n_tests++;
            if (!got || rd !== e) begin
                n_fail++; $display("FAIL reset_read[%0d]: got %h ack=%0d want %h", w, rd, got, e);
            end
        end
    endtask

    task automatic test_sel_out;
        logic [31:0] rd, e; bit got; int lat; logic a2;
        bus(1'b1, 8'h00, 32'h1, 4'hF, 1'b1, rd, got, lat, a2);
        n_tests++;
        if (!got || lat != 1 || a2 !== 1'b0) begin
            n_fail++; $display("FAIL ack_timing: ack=%0d lat=%0d next=%b want 1/1/0", got, lat, a2);
        end
        bus(1'b1, 8'h08, 32'h1, 4'hF, 1'b0, rd, got, lat, a2);
        bus(1'b1, 8'h10, 32'h1, 4'hF, 1'b0, rd, got, lat, a2);
        core_out = 38'h2A_AAAA_AAAA; core_oeb = 38'h15_5555_5555; #1;
        n_tests++;
        if (io_out !== 38'h2A_AAAA_AAAB || io_oeb !== 38'h15_5555_5554) begin
            n_fail++; $display("FAIL pad_mux: io_out=%h io_oeb=%h want 2aaaaaaaab/1555555554", io_out, io_oeb);
        end
        exp_q.push_back(32'h1);
        bus(1'b0, 8'h00, 32'h0, 4'hF, 1'b0, rd, got, lat, a2);
        e = exp_q.pop_front();
        n_tests++;
        if (!got || rd !== e) begin
            n_fail++; $display("FAIL sel_lo_rd: got %h want %h", rd, e);
        end
    endtask

    task automatic test_hi_mask;
        logic [31:0] rd, e; bit got; int lat; logic a2;
        bus(1'b1, 8'h0C, 32'hFFFF_FFFF, 4'b0001, 1'b0, rd, got, lat, a2);
        exp_q.push_back(32'h3F);
        bus(1'b0, 8'h0C, 32'h0, 4'hF, 1'b0, rd, got, lat, a2);
        e = exp_q.pop_front();
        n_tests++;
        if (!got || rd !== e) begin
            n_fail++; $display("FAIL out_hi_mask: got %h want %h", rd, e);
        end
        bus(1'b1, 8'h0C, 32'h0, 4'b0010, 1'b0, rd, got, lat, a2);
        bus(1'b1, 8'h0D, 32'h15, 4'b0001, 1'b0, rd, got, lat, a2);
        exp_q.push_back(32'h15);
        bus(1'b0, 8'h0C, 32'h0, 4'hF, 1'b0, rd, got, lat, a2);
        e = exp_q.pop_front();
        n_tests++;
        if (!got || rd !== e) begin
            n_fail++; $display("FAIL out_hi_lanes: got %h want %h", rd, e);
        end
        bus(1'b1, 8'h08, 32'hFFFF_FFFF, 4'b0010, 1'b0, rd, got, lat, a2);
        exp_q.push_back(32'h0000_FF01);
        bus(1'b0, 8'h08, 32'h0, 4'hF, 1'b0, rd, got, lat, a2);
        e = exp_q.pop_front();
        n_tests++;
        if (!got || rd !== e) begin
            n_fail++; $display("FAIL out_lo_lane1: got %h want %h", rd, e);
        end
    endtask

    task automatic test_irq;
        logic [31:0] rd, e; bit got; int lat; logic a2; int first;
        bus(1'b1, 8'h20, 32'h2, 4'hF, 1'b0, rd, got, lat, a2);
        bus(1'b1, 8'h28, 32'h2, 4'hF, 1'b0, rd, got, lat, a2);
        io_in[1] = 1'b1;
        first = 0;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            if (irq[1] && first == 0) first = k;
        end
        n_tests++;
        if (first != SYNC + 2 || irq !== 3'b010) begin
            n_fail++; $display("FAIL irq_latency: first=%0d irq=%b want %0d/010", first, irq, SYNC + 2);
        end
        exp_q.push_back(32'h2);
        bus(1'b0, 8'h30, 32'h0, 4'hF, 1'b0, rd, got, lat, a2);
        e = exp_q.pop_front();
        n_tests++;
        if (!got || rd !== e) begin
            n_fail++; $display("FAIL stat_rise: got %h want %h", rd, e);
        end
        bus(1'b1, 8'h30, 32'h2, 4'hF, 1'b0, rd, got, lat, a2);
        n_tests++;
        if (irq[1] !== 1'b1) begin
            n_fail++; $display("FAIL irq_hold_at_ack: got %b want 1", irq[1]);
        end
        @(posedge clk); #1;
        n_tests++;
        if (irq !== 3'b000) begin
            n_fail++; $display("FAIL irq_w1c: got %b want 000", irq);
        end
        // pad 1 falls (rising-only) and pad 3 rises then falls (falling-only)
        io_in[1] = 1'b0; io_in[3] = 1'b1;
        repeat (6) @(posedge clk); #1;
        io_in[3] = 1'b0;
        repeat (6) @(posedge clk);
        exp_q.push_back(32'h8);
        bus(1'b0, 8'h30, 32'h0, 4'hF, 1'b0, rd, got, lat, a2);
        e = exp_q.pop_front();
        n_tests++;
        if (!got || rd !== e || irq !== 3'b000) begin
            n_fail++; $display("FAIL stat_fall: got %h irq=%b want %h irq=000", rd, irq, e);
        end
        bus(1'b1, 8'h20, 32'hA, 4'hF, 1'b0, rd, got, lat, a2);
        @(posedge clk); #1;
        n_tests++;
        if (irq !== 3'b001) begin
            n_fail++; $display("FAIL irq_route_pad3: got %b want 001", irq);
        end
        bus(1'b1, 8'h30, 32'h8, 4'hF, 1'b0, rd, got, lat, a2);
        bus(1'b1, 8'h20, 32'h0, 4'hF, 1'b0, rd, got, lat, a2);
    endtask

    task automatic test_set_wins;
        logic [31:0] rd, e; bit got; int lat; logic a2;
        bus(1'b1, 8'h28, 32'h12, 4'hF, 1'b0, rd, got, lat, a2);
        io_in[4] = 1'b1;
        repeat (5) @(posedge clk);
        exp_q.push_back(32'h10);
        bus(1'b0, 8'h30, 32'h0, 4'hF, 1'b0, rd, got, lat, a2);
        e = exp_q.pop_front();
        n_tests++;
        if (!got || rd !== e) begin
            n_fail++; $display("FAIL stat_pad4: got %h want %h", rd, e);
        end
        io_in[4] = 1'b0;
        repeat (5) @(posedge clk); #1;
        io_in[4] = 1'b1;
        @(posedge clk);
        // W1C is sampled on the same edge that latches the synchronised rise
        bus(1'b1, 8'h30, 32'h10, 4'hF, 1'b0, rd, got, lat, a2);
        exp_q.push_back(32'h10);
        bus(1'b0, 8'h30, 32'h0, 4'hF, 1'b0, rd, got, lat, a2);
        e = exp_q.pop_front();
        n_tests++;
        if (!got || rd !== e) begin
            n_fail++; $display("FAIL set_wins: got %h want %h", rd, e);
        end
        bus(1'b1, 8'h30, 32'h10, 4'hF, 1'b0, rd, got, lat, a2);
        exp_q.push_back(32'h0);
        bus(1'b0, 8'h30, 32'h0, 4'hF, 1'b0, rd, got, lat, a2);
        e = exp_q.pop_front();
        n_tests++;
        if (!got || rd !== e) begin
            n_fail++; $display("FAIL w1c_pad4: got %h want %h", rd, e);
        end
    endtask

    task automatic test_input;
        logic [31:0] rd, e; bit got; int lat; logic a2;
        io_in[37:32] = 6'h2A;
        repeat (4) @(posedge clk);
        exp_q.push_back(32'h2A);
        bus(1'b0, 8'h1C, 32'h0, 4'hF, 1'b0, rd, got, lat, a2);
        e = exp_q.pop_front();
        n_tests++;
        if (!got || rd !== e) begin
            n_fail++; $display("FAIL in_hi: got %h want %h", rd, e);
        end
        bus(1'b1, 8'h18, 32'hFFFF_FFFF, 4'hF, 1'b0, rd, got, lat, a2);
        exp_q.push_back(32'h10);
        bus(1'b0, 8'h18, 32'h0, 4'hF, 1'b0, rd, got, lat, a2);
        e = exp_q.pop_front();
        n_tests++;
        if (!got || rd !== e) begin
            n_fail++; $display("FAIL in_lo_ro: got %h want %h", rd, e);
        end
    endtask

    task automatic test_window;
        logic [31:0] rd, e; bit got; int lat; logic a2;
        bus(1'b1, 8'h48, 32'h0, 4'hF, 1'b0, rd, got, lat, a2);
        n_tests++;
        if (got) begin
            n_fail++; $display("FAIL out_of_window: ack seen, want none");
        end
        bus(1'b1, 8'h38, 32'hFFFF_FFFF, 4'hF, 1'b0, rd, got, lat, a2);
        for (int w = 0; w < 2; w++) begin
            exp_q.push_back(32'h0);
            bus(1'b0, 8'(8'h38 + w * 4), 32'h0, 4'hF, 1'b0, rd, got, lat, a2);
            e = exp_q.pop_front();
            n_tests++;
            if (!got || rd !== e) begin
                n_fail++; $display("FAIL reserved[%0d]: got %h ack=%0d want %h", w, rd, got, e);
            end
        end
        exp_q.push_back(32'h0000_FF01);
        bus(1'b0, 8'h08, 32'h0, 4'hF, 1'b0, rd, got, lat, a2);
        e = exp_q.pop_front();
        n_tests++;
        if (!got || rd !== e) begin
            n_fail++; $display("FAIL no_alias: got %h want %h", rd, e);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] rd, e; bit got; int lat; logic a2;
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 1; adr = BASE + 32'h08; dat = 32'hDEAD_BEEF; sel = 4'hF;
        #2 rst = 1; #1;
        n_tests++;
        if (ack !== 1'b0) begin
            n_fail++; $display("FAIL rst_ack_now: got %b want 0", ack);
        end
        @(posedge clk); #1;
        n_tests++;
        if (ack !== 1'b0 || irq !== 3'b000) begin
            n_fail++; $display("FAIL rst_ack_edge: ack=%b irq=%b want 0/000", ack, irq);
        end
        repeat (2) @(posedge clk); #1;
        cyc = 0; stb = 0; we = 0; rst = 0;
        repeat (5) @(posedge clk); #1;
        n_tests++;
        if (io_out !== core_out) begin
            n_fail++; $display("FAIL rst_mux: io_out=%h want %h", io_out, core_out);
        end
        for (int w = 0; w < 3; w++) begin
            exp_q.push_back(32'h0);
            bus(1'b0, (w == 0) ? 8'h08 : ((w == 1) ? 8'h30 : 8'h34), 32'h0, 4'hF, 1'b0,
                rd, got, lat, a2);
            e = exp_q.pop_front();
            n_tests++;
            if (!got || rd !== e) begin
                n_fail++; $display("FAIL rst_regs[%0d]: got %h ack=%0d want %h", w, rd, got, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_sel_out();
        test_hi_mask();
        test_irq();
        test_set_wins();
        test_input();
        test_window();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
